bird_column: RTL
================

// Module: bird_column
// PURPOSE
//  Parametrised bird-position tracker for one LED column of the playfield; replaces the per-LED
//  cell chain with a single block holding the bird's row, generalised to HEIGHT rows and a
//  JUMP-row flap. Adds game-phase control: IDLE (waiting to start), PLAY, DEAD (floor or
//  external crash), plus ceiling clamp. Drives the column's one-hot LED vector and status to top.
// PARAMETERS
//  HEIGHT  8          rows in the column, >=2; row 0 = bottom (floor), HEIGHT-1 = top
//  JUMP    1          rows moved up per flap, 1..HEIGHT-1
//  START   HEIGHT/2   row loaded on reset and on restart, 0..HEIGHT-1
// PORTS
//  clk      in   1                  system clock
//  reset    in   1                  synchronous, active-high
//  button   in   1                  flap request, single-cycle pulse (already edge-detected)
//  fall     in   1                  gravity tick, single-cycle pulse
//  crash    in   1                  external collision (pipe) pulse
//  lightOn  out  HEIGHT             one-hot LED vector, lightOn[pos]=1
//  pos      out  $clog2(HEIGHT)     current bird row
//  playing  out  1                  1 in PLAY
//  dead     out  1                  1 in DEAD
// BEHAVIOUR
//  - All outputs registered; every input event takes effect on the next rising clk edge
//    (1-cycle latency). Inputs sampled only at posedge clk.
//  - reset: state=IDLE, pos=START, lightOn=1<<START, playing=0, dead=0. Reset overrides
//    everything in the same cycle, including mid-flap or mid-fall.
//  - IDLE: fall and crash ignored; pos held. button -> PLAY, pos unchanged (start press does
//    not flap).
//  - PLAY, per cycle, in priority order:
//     1. crash=1        -> DEAD, pos held (crash beats button/fall same cycle)
//     2. button=1       -> pos = min(pos+JUMP, HEIGHT-1); fall same cycle ignored
//     3. fall=1, pos>0  -> pos = pos-1
//     4. fall=1, pos==0 -> DEAD, pos stays 0 (floor hit)
//     5. none           -> hold
//  - Ceiling: flap never wraps; pos+JUMP computed one bit wider than pos, then clamped.
//    Flap at HEIGHT-1 holds HEIGHT-1, stays PLAY.
//  - Landing on row 0 via fall is NOT death; only a fall while already at row 0 is.
//  - DEAD: pos, lightOn frozen; fall/crash ignored. button -> IDLE with pos=START.
//  - lightOn always exactly one-hot and always equals 1<<pos (no blank cycle during moves).
//  - playing = (state==PLAY); dead = (state==DEAD); never both 1.
//  - State encoding free; unreachable encodings must recover to IDLE, pos=START.
// TESTING (HEIGHT=8, JUMP=2, START=4 unless noted)
//  1. reset; fall x3; crash -> state IDLE, pos=4, lightOn=8'b0001_0000 throughout.
//  2. button (start); fall x4 -> playing=1, pos 4,3,2,1,0; one more fall -> dead=1, pos=0,
//     lightOn=8'b0000_0001; further fall/crash -> no change.
//  3. PLAY at pos=5: button -> pos=7; button -> pos=7 (clamped, no wrap), lightOn=8'b1000_0000;
//     button+fall same cycle at pos=3 -> pos=5.
//  4. PLAY at pos=3: crash+button same cycle -> dead=1, pos=3; button -> IDLE, pos=4,
//     playing=0, dead=0; button -> PLAY, pos=4.
//  5. reset asserted the cycle a button arrives in PLAY at pos=6 -> IDLE, pos=4 next edge.
//  6. HEIGHT=2, JUMP=1, START=1: start; fall -> pos=0; button -> pos=1; button -> pos=1;
//     fall x2 -> dead=1. Random pulse soak: assert lightOn==1<<pos and one-hot every cycle.

Source files
------------

// File: rtl/bird_column_if.sv
// Handshake bundle between the playfield controller and one bird column:
// event pulses in, LED vector and game status out.
interface bird_column_if #(
  parameter int HEIGHT = 8
);
  localparam int PW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  logic              button;
  logic              fall;
  logic              crash;
  logic [HEIGHT-1:0] lightOn;
  logic [PW-1:0]     pos;
  logic              playing;
  logic              dead;

  modport master (
    output button, fall, crash,
    input  lightOn, pos, playing, dead
  );

  modport slave (
    input  button, fall, crash,
    output lightOn, pos, playing, dead
  );
endinterface

// File: rtl/bird_column.sv
// Bird row tracker for one LED column: IDLE/PLAY/DEAD game phase, flap with
// ceiling clamp, gravity with floor death, registered one-hot LED drive.
module bird_column #(
  parameter int HEIGHT = 8,
  parameter int JUMP   = 1,
  parameter int START  = HEIGHT / 2
) (
  input logic           clk,
  input logic           reset,
  bird_column_if.slave  io
);
  localparam int PW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [PW-1:0]     TOP_ROW   = PW'(HEIGHT - 1);
  localparam logic [PW:0]       TOP_WIDE  = (PW + 1)'(HEIGHT - 1);
  localparam logic [PW:0]       JUMP_WIDE = (PW + 1)'(JUMP);
  localparam logic [PW-1:0]     START_ROW = PW'(START);
  localparam logic [HEIGHT-1:0] ONE_HOT0  = HEIGHT'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DEAD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     pos_q, pos_d;
  logic [HEIGHT-1:0] light_q, light_d;
  logic              playing_q, playing_d;
  logic              dead_q, dead_d;
  logic [PW:0]       flapSum;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pos_q     <= START_ROW;
      light_q   <= ONE_HOT0 << START_ROW;
      playing_q <= 1'b0;
      dead_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      light_q   <= light_d;
      playing_q <= playing_d;
      dead_q    <= dead_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    // One bit wider than pos so a flap near the top clamps instead of wrapping.
    flapSum = {1'b0, pos_q} + JUMP_WIDE;

    if ({1'b0, pos_q} > TOP_WIDE) begin
      state_d = IDLE;
      pos_d   = START_ROW;
    end else begin
      case (state_q)
        IDLE: begin
          if (io.button) state_d = PLAY;
        end
        PLAY: begin
          if (io.crash) begin
            state_d = DEAD;
          end else if (io.button) begin
            pos_d = (flapSum > TOP_WIDE) ? TOP_ROW : flapSum[PW-1:0];
          end else if (io.fall) begin
            if (pos_q != '0) pos_d = pos_q - 1'b1;
            else             state_d = DEAD;
          end
        end
        DEAD: begin
          if (io.button) begin
            state_d = IDLE;
            pos_d   = START_ROW;
          end
        end
        default: begin
          state_d = IDLE;
          pos_d   = START_ROW;
        end
      endcase
    end

    // Derived from next-state values so LEDs track pos with no blank cycle.
    light_d   = ONE_HOT0 << pos_d;
    playing_d = (state_d == PLAY);
    dead_d    = (state_d == DEAD);
  end

  assign io.lightOn = light_q;
  assign io.pos     = pos_q;
  assign io.playing = playing_q;
  assign io.dead    = dead_q;
endmodule
